// File: rtl/aes_composite_dec.sv
// rtl/aes_composite_dec.sv - AES-128 iterative decryptor, inverse S-box in GF((2^4)^2)
// Ports: CLK clock; RST sync active-high reset; Kin/Krdy key load, Kvld schedule-ready pulse;
//        Din/Drdy ciphertext load, Dout plaintext, Dvld result pulse; EN freeze; BSY busy.
module aes_composite_dec (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] Kin,
    input  logic [127:0] Din,
    output logic [127:0] Dout,
    input  logic         Krdy,
    input  logic         Drdy,
    output logic         Kvld,
    output logic         Dvld,
    input  logic         EN,
    output logic         BSY
);

    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC} state_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // GF(2^4) modulo x^4 + x + 1
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^14 = a^-1 in GF(2^4); maps 0 to 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    // Basis change between the AES field and GF(2^4)[Y]/(Y^2+Y+0xC).
    // Composite bits [7:4] are the Y coefficient; GF(2^4) root is 0xE1, Y root is 0xA2.
    function automatic logic [7:0] to_comp(input logic [7:0] a);
        return ({8{a[0]}} & 8'h01) ^ ({8{a[1]}} & 8'h40) ^ ({8{a[2]}} & 8'h37) ^
               ({8{a[3]}} & 8'h3f) ^ ({8{a[4]}} & 8'h5f) ^ ({8{a[5]}} & 8'he2) ^
               ({8{a[6]}} & 8'h53) ^ ({8{a[7]}} & 8'hb2);
    endfunction

    function automatic logic [7:0] from_comp(input logic [7:0] c);
        return ({8{c[0]}} & 8'h01) ^ ({8{c[1]}} & 8'he1) ^ ({8{c[2]}} & 8'h5c) ^
               ({8{c[3]}} & 8'h0c) ^ ({8{c[4]}} & 8'ha2) ^ ({8{c[5]}} & 8'h1a) ^
               ({8{c[6]}} & 8'h02) ^ ({8{c[7]}} & 8'hd9);
    endfunction

    // (hY + l)^-1 = (hY + h + l) / (h^2*lambda + h*l + l^2)
    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [7:0] c;
        logic [3:0] d, di;
        c  = to_comp(a);
        d  = gf16_mul(gf16_mul(c[7:4], c[7:4]), 4'hc) ^ gf16_mul(c[7:4], c[3:0]) ^
             gf16_mul(c[3:0], c[3:0]);
        di = gf16_inv(d);
        return from_comp({gf16_mul(c[7:4], di), gf16_mul(c[7:4] ^ c[3:0], di)});
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf256_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf256_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Recovers the previous round key; rc is the constant that produced k
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        return {k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0}, w1, w2, w3};
    endfunction

    // Byte i = row (i % 4), column (i / 4); byte 0 sits in bits [127:120]
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0] b [16];
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                b[4*c+w] = inv_sbox(s[8*(15-(4*((c-w+4)%4)+w)) +: 8]) ^ k[8*(15-(4*c+w)) +: 8];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(15-(4*c+w)) +: 8] = !mix ? b[4*c+w] :
                    gmul(b[4*c+w], 4'he) ^ gmul(b[4*c+(w+1)%4], 4'hb) ^
                    gmul(b[4*c+(w+2)%4], 4'hd) ^ gmul(b[4*c+(w+3)%4], 4'h9);
        return r;
    endfunction

    state_t        state, state_nxt;
    logic [3:0]    rnd;
    logic [7:0]    rcon;
    logic [127:0]  rkey, dkey, dat;
    logic          key_ok;
    logic          load_key, load_dat, kexp_step, dec_step, done_k, done_d;
    logic [127:0]  rkey_fwd, rkey_prev, dat_rnd;

    assign rkey_fwd  = key_fwd(rkey, rcon);
    assign rkey_prev = key_inv(rkey, rcon);
    assign dat_rnd   = inv_round(dat, rkey_prev, rnd != 4'd9);
    assign Dout      = dat;
    assign BSY       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        load_dat  = 1'b0;
        kexp_step = 1'b0;
        dec_step  = 1'b0;
        done_k    = 1'b0;
        done_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Krdy) begin
                    load_key  = 1'b1;
                    state_nxt = S_KEXP;
                end else if (Drdy && key_ok) begin
                    load_dat  = 1'b1;
                    state_nxt = S_DEC;
                end
            end
            S_KEXP: begin
                kexp_step = 1'b1;
                if (rnd == 4'd9) begin
                    done_k    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DEC: begin
                // Ten rounds, then one cycle to publish the result
                if (rnd == 4'd10) begin
                    done_d    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    dec_step = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            rnd    <= 4'd0;
            rcon   <= 8'h01;
            rkey   <= '0;
            dkey   <= '0;
            dat    <= '0;
            key_ok <= 1'b0;
            Kvld   <= 1'b0;
            Dvld   <= 1'b0;
        end else if (EN) begin
            state <= state_nxt;
            Kvld  <= done_k;
            Dvld  <= done_d;
            if (load_key) begin
                rkey   <= Kin;
                rcon   <= 8'h01;
                rnd    <= 4'd0;
                key_ok <= 1'b0;
            end
            if (kexp_step) begin
                rkey <= rkey_fwd;
                rcon <= xt(rcon);
                rnd  <= rnd + 4'd1;
            end
            if (done_k) begin
                dkey   <= rkey_fwd;
                key_ok <= 1'b1;
            end
            if (load_dat) begin
                dat  <= Din ^ dkey;
                rkey <= dkey;
                rcon <= 8'h36;
                rnd  <= 4'd0;
            end
            if (dec_step) begin
                rkey <= rkey_prev;
                rcon <= (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};
                dat  <= dat_rnd;
                rnd  <= rnd + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_composite_dec.sv
// tb/tb_aes_composite_dec.sv - self-checking bench for aes_composite_dec
module tb_aes_composite_dec;

    logic         CLK, RST, Krdy, Drdy, EN;
    logic [127:0] Kin, Din, Dout;
    logic         Kvld, Dvld, BSY;

    aes_composite_dec dut (
        .CLK(CLK), .RST(RST), .Kin(Kin), .Din(Din), .Dout(Dout),
        .Krdy(Krdy), .Drdy(Drdy), .Kvld(Kvld), .Dvld(Dvld), .EN(EN), .BSY(BSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] sb [256];
    logic [7:0] aff_c;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward AES-128, textbook form; expected plaintext is the value fed to it
    function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rd == 10) ? t[4*c+r] :
                        gm(t[4*c+r], 8'h02) ^ gm(t[4*c+(r+1)%4], 8'h03) ^
                        t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_for(input bit want_k, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((want_k && Kvld) || (!want_k && Dvld)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic watch(input int n, output bit saw_bsy, output bit saw_dvld);
        saw_bsy  = 1'b0;
        saw_dvld = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (BSY)  saw_bsy  = 1'b1;
            if (Dvld) saw_dvld = 1'b1;
        end
    endtask

    task automatic load_key(input logic [127:0] k, input string tag);
        int cyc;
        Kin  = k;
        Krdy = 1'b1;
        tick();
        Krdy = 1'b0;
        chk({tag, "_kexp_bsy"}, BSY, 1);
        wait_for(1'b1, 40, cyc);
        chk({tag, "_kvld_lat"}, cyc, 10);
        tick();
        chk({tag, "_kvld_pulse"}, Kvld, 0);
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int cyc;
        Din  = ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        chk({tag, "_dec_bsy"}, BSY, 1);
        wait_for(1'b0, 40, cyc);
        chk({tag, "_dvld_lat"}, cyc, 11);
        chk({tag, "_dout"}, Dout, pt);
        tick();
        chk({tag, "_dvld_pulse"}, {BSY, Dvld}, 0);
        chk({tag, "_dout_hold"}, Dout, pt);
    endtask

    initial begin
        int           cyc;
        bit           saw_b, saw_d;
        logic [127:0] rk, rp;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        // S-box from its definition: brute-force field inverse, then the affine map
        aff_c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv, sv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
            sb[a] = sv;
        end

        RST = 1'b1; EN = 1'b1; Krdy = 1'b0; Drdy = 1'b0; Kin = '0; Din = '0;
        tick();
        tick();
        chk("reset_outputs", {Dout, BSY, Kvld, Dvld}, 0);
        RST = 1'b0;

        // Ciphertext request with no key loaded
        Din  = vecs[0].ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        watch(15, saw_b, saw_d);
        chk("nokey_bsy", saw_b, 0);
        chk("nokey_dvld", saw_d, 0);
        chk("nokey_dout", Dout, 0);

        // Key and data together: key wins, data dropped
        Kin  = vecs[0].key;
        Din  = vecs[0].ct;
        Krdy = 1'b1;
        Drdy = 1'b1;
        tick();
        Krdy = 1'b0;
        Drdy = 1'b0;
        wait_for(1'b1, 40, cyc);
        chk("both_kvld_lat", cyc, 10);
        watch(15, saw_b, saw_d);
        chk("both_no_dvld", saw_d, 0);

        for (int i = 0; i < 3; i++) begin
            load_key(vecs[i].key, $sformatf("vec%0d", i));
            decrypt(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));
            decrypt(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d_again", i));
        end

        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            load_key(rk, $sformatf("rnd%0d", i));
            for (int j = 0; j < 2; j++) begin
                rp = {$urandom, $urandom, $urandom, $urandom};
                decrypt(model_enc(rk, rp), rp, $sformatf("rnd%0d_%0d", i, j));
            end
        end

        // Freeze 5 cycles mid-decryption
        load_key(vecs[0].key, "frz");
        Din  = vecs[0].ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        repeat (4) tick();
        EN = 1'b0;
        watch(5, saw_b, saw_d);
        chk("frz_no_dvld", saw_d, 0);
        chk("frz_bsy_held", BSY, 1);
        EN = 1'b1;
        wait_for(1'b0, 40, cyc);
        chk("frz_dvld_lat", cyc, 7);
        chk("frz_dout", Dout, vecs[0].pt);
        EN = 1'b0;
        tick();
        tick();
        chk("frz_dvld_stretch", Dvld, 1);
        EN = 1'b1;
        tick();
        chk("frz_dvld_drop", Dvld, 0);

        // Requests while busy are ignored
        Din  = vecs[0].ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        repeat (3) tick();
        Kin  = vecs[1].key;
        Din  = vecs[1].ct;
        Krdy = 1'b1;
        Drdy = 1'b1;
        tick();
        Krdy = 1'b0;
        Drdy = 1'b0;
        wait_for(1'b0, 40, cyc);
        chk("busy_dvld_lat", cyc, 7);
        chk("busy_dout", Dout, vecs[0].pt);
        watch(15, saw_b, saw_d);
        chk("busy_no_restart", {saw_b, saw_d}, 0);
        decrypt(vecs[0].ct, vecs[0].pt, "busy_key_kept");

        // Reset at decryption round 5
        Din  = vecs[0].ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_outputs", {Dout, BSY, Kvld, Dvld}, 0);
        watch(15, saw_b, saw_d);
        chk("rst_no_dvld", saw_d, 0);
        Din  = vecs[0].ct;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        watch(15, saw_b, saw_d);
        chk("rst_drdy_ignored", {saw_b, saw_d}, 0);
        load_key(vecs[1].key, "rst_reload");
        decrypt(vecs[1].ct, vecs[1].pt, "rst_reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_composite_dec.md
AES_COMPOSITE_DEC -- requirements
Module: aes_composite_dec

Interface
REQ-001 Parameters: none.
REQ-002 CLK   in   1    system clock; all state updates on its rising edge.
REQ-003 RST   in   1    reset, synchronous, active-high.
REQ-004 Kin   in   128  cipher key (AES-128), byte 0 in bits [127:120].
REQ-005 Din   in   128  ciphertext input, byte 0 in bits [127:120].
REQ-006 Dout  out  128  plaintext output, same byte order as Din.
REQ-007 Krdy  in   1    key load request, sampled when EN=1.
REQ-008 Drdy  in   1    ciphertext load request, sampled when EN=1.
REQ-009 Kvld  out  1    one-cycle pulse: decryption key schedule ready.
REQ-010 Dvld  out  1    one-cycle pulse: Dout holds a new plaintext.
REQ-011 EN    in   1    block enable; EN=0 freezes all registers and outputs.
REQ-012 BSY   out  1    high while key setup or decryption is in progress.

Function
REQ-013 The block SHALL implement FIPS-197 AES-128 inverse cipher, one round per cycle, with the inverse S-box realised in composite field GF((2^4)^2).
REQ-014 The block SHALL be in one of the states IDLE, KEXP (forward key expansion) or DEC (decryption rounds).
REQ-015 IDLE + Krdy: latch Kin into key and rkey, set rcon=0x01, round counter=0, clear key_ok, BSY=1, go to KEXP.
REQ-016 KEXP: each cycle rkey <= forward expansion of rkey with rcon, rcon <= xtime(rcon); after 10 steps store rkey as last round key dkey, set key_ok, pulse Kvld, go to IDLE.
REQ-017 Kvld SHALL rise 10 cycles after the cycle in which Krdy was accepted, for exactly one cycle.
REQ-018 IDLE + Drdy + key_ok: dat <= Din ^ dkey, rkey <= dkey, rcon <= 0x36, round counter=0, BSY=1, go to DEC.
REQ-019 DEC: each cycle rkey <= inverse key step of rkey with rcon (prior round key), rcon <= inverse xtime (0x1B->0x80, else shift right), dat <= InvShiftRows, InvSubBytes, AddRoundKey(prior key), then InvMixColumns on rounds 1-9 only.
REQ-020 After the 10th DEC cycle (round without InvMixColumns) the block SHALL pulse Dvld for one cycle, drop BSY and return to IDLE; latency Drdy-accept to Dvld = 11 cycles.
REQ-021 Dout SHALL equal the dat register; it is valid from the Dvld cycle until the next accepted Drdy.
REQ-022 Krdy and Drdy SHALL be ignored while BSY=1; no queuing.
REQ-023 Krdy and Drdy asserted together in IDLE: key load wins, Drdy dropped.
REQ-024 Drdy in IDLE with key_ok=0 SHALL be ignored (no BSY, no Dvld).
REQ-025 key_ok and dkey SHALL persist across any number of decryptions until the next accepted Krdy.
REQ-026 EN=0 in any state SHALL hold state, counters, rcon, dat, rkey and all outputs; operation resumes exactly where frozen; Kvld/Dvld pulses are stretched while frozen.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, dat=0, key=0, rkey=0, dkey=0, rcon=0x01, key_ok=0, Kvld=0, Dvld=0, BSY=0, regardless of EN.
REQ-028 RST mid-KEXP or mid-DEC SHALL abort; no Kvld/Dvld pulse follows and a new Krdy is required before decryption.

Verification
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, Krdy -> Kvld 10 cycles later; Din 3925841d02dc09fbdc118597196a0b32, Drdy -> Dvld 11 cycles later, Dout 3243f6a8885a308d313198a2e0370734.
REQ-030 Key 000102030405060708090a0b0c0d0e0f; Din 69c4e0d86a7b0430d8cdb78070b4c55a -> Dout 00112233445566778899aabbccddeeff; second Drdy without reload -> same result.
REQ-031 Drdy after reset, no key -> BSY stays 0, no Dvld, Dout 0; Krdy+Drdy same cycle -> only Kvld, no Dvld.
REQ-032 EN=0 for 5 cycles mid-DEC -> Dvld delayed by exactly 5 cycles, Dout still correct; Drdy/Krdy during BSY -> ignored, result unchanged.
REQ-033 RST pulse at DEC round 5 -> all outputs 0 next cycle, no Dvld, subsequent Drdy ignored until new key loaded.
